// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory request arbiter: requester IDs, grant states, size codes, command bundle.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    localparam logic ID_INST = 1'b0;
    localparam logic ID_DATA = 1'b1;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } arb_state_t;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    typedef struct packed {
        logic        wr;
        logic [1:0]  size;
        logic [3:0]  wstrb;
        logic [31:0] addr;
        logic [31:0] wdata;
    } mem_cmd_t;

endpackage

// File: rtl/arb_id_fifo.sv
// Order FIFO of 1-bit requester IDs, depth DEPTH, pointers wrap modulo DEPTH.
// Latency: head valid the cycle after push; pop and push may coincide.
// Backpressure: push ignored when full, pop ignored when empty.
module arb_id_fifo #(
    parameter int  DEPTH = 2,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          din,
    input  logic          pop,
    output logic          head,
    output logic [CW-1:0] cnt,
    output logic          full,
    output logic          empty
);

    logic [DEPTH-1:0] mem;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = (cnt == CW'(DEPTH));
    assign empty   = (cnt == '0);
    assign push_ok = push & ~full;
    assign pop_ok  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ptr_inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/mem_req_arb.sv
// Merges fetch and load/store requests onto one sram-like port, returns responses in order; optional perf counters under MEM_ARB_PERF_CNT_EN.
// Latency: request to mem_req 0 cycles, addr_ok/data_ok combinational from the memory handshake.
// Backpressure: grant held (locked) until mem_addr_ok; mem_req dropped while MAX_OUTSTANDING transactions await data_ok.
module mem_req_arb
    import mem_arb_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_req,
    input  logic [31:0] inst_addr,
    output logic        inst_addr_ok,
    output logic        inst_data_ok,
    output logic [31:0] inst_rdata,
    input  logic        data_req,
    input  logic        data_wr,
    input  logic [1:0]  data_size,
    input  logic [3:0]  data_wstrb,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_wdata,
    output logic        data_addr_ok,
    output logic        data_data_ok,
    output logic [31:0] data_rdata,
    output logic        mem_req,
    output logic        mem_wr,
    output logic [1:0]  mem_size,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic        mem_addr_ok,
    input  logic        mem_data_ok,
    input  logic [31:0] mem_rdata
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0] perf_inst_grant,
    output logic [31:0] perf_data_grant,
    output logic [31:0] perf_stall
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    arb_state_t       state;
    logic             gnt_inst;
    logic             gnt_data;
    logic             slot_free;
    logic             hs;
    logic             pop;
    logic             fifo_head;
    logic [CNT_W-1:0] fifo_cnt;
    logic             fifo_full;
    logic             fifo_empty;
    mem_cmd_t         inst_cmd;
    mem_cmd_t         data_cmd;
    mem_cmd_t         cmd;

    // A locked grant sticks to its requester; otherwise loads/stores win over fetches.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        case (state)
            LOCK_INST: gnt_inst = 1'b1;
            LOCK_DATA: gnt_data = 1'b1;
            default: begin
                if (data_req)      gnt_data = 1'b1;
                else if (inst_req) gnt_inst = 1'b1;
            end
        endcase
    end

    // Slot availability uses the registered count only, so a same-cycle pop never frees a slot.
    assign slot_free = ~fifo_full;
    assign mem_req   = ~reset & slot_free & ((gnt_inst & inst_req) | (gnt_data & data_req));
    assign hs        = mem_req & mem_addr_ok;

    assign inst_cmd = '{wr: 1'b0, size: SIZE_WORD, wstrb: 4'h0, addr: inst_addr, wdata: 32'h0};
    assign data_cmd = '{wr: data_wr, size: data_size, wstrb: data_wstrb, addr: data_addr, wdata: data_wdata};

    always_comb begin
        cmd = '0;
        if (!reset) begin
            if (gnt_data)      cmd = data_cmd;
            else if (gnt_inst) cmd = inst_cmd;
        end
    end

    assign mem_wr    = cmd.wr;
    assign mem_size  = cmd.size;
    assign mem_wstrb = cmd.wstrb;
    assign mem_addr  = cmd.addr;
    assign mem_wdata = cmd.wdata;

    assign inst_addr_ok = hs & gnt_inst;
    assign data_addr_ok = hs & gnt_data;

    // Responses with nothing outstanding (e.g. stale after reset) are dropped.
    assign pop          = ~reset & mem_data_ok & ~fifo_empty;
    assign inst_data_ok = pop & (fifo_head == ID_INST);
    assign data_data_ok = pop & (fifo_head == ID_DATA);
    assign inst_rdata   = reset ? 32'h0 : mem_rdata;
    assign data_rdata   = reset ? 32'h0 : mem_rdata;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else if (mem_req && !mem_addr_ok) begin
            state <= gnt_data ? LOCK_DATA : LOCK_INST;
        end else begin
            state <= IDLE;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_id_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (hs),
        .din   (gnt_data ? ID_DATA : ID_INST),
        .pop   (pop),
        .head  (fifo_head),
        .cnt   (fifo_cnt),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    a_cnt_range: assert property (@(posedge clk) disable iff (reset)
        fifo_cnt <= CNT_W'(MAX_OUTSTANDING));

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_inst_grant <= '0;
            perf_data_grant <= '0;
            perf_stall      <= '0;
        end else begin
            if (inst_addr_ok)                   perf_inst_grant <= perf_inst_grant + 32'd1;
            if (data_addr_ok)                   perf_data_grant <= perf_data_grant + 32'd1;
            if ((inst_req || data_req) && !hs)  perf_stall      <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: doc/mem_req_arb.md
# mem_req_arb

Two-into-one arbiter for the CPU's sram-like memory port. It merges instruction-fetch requests (IF stage) and data load/store requests (EX stage, issued one cycle ahead of MEM) onto a single downstream request/response channel. It tracks outstanding transactions in order and routes each returning `data_ok`/`rdata` back to the requester that issued it. It sits between the pipeline stages and the memory bridge in `mycpu_top`.

## Interface
- `MAX_OUTSTANDING`, 2: maximum number of accepted transactions awaiting `data_ok`, allowed range 1..4.
- `clk  in  1`: the single clock; all state is updated on the rising edge.
- `reset  in  1`: asynchronous, active-high reset.
- `inst_req  in  1`, `inst_addr  in  32`: fetch request, always a 4-byte read.
- `inst_addr_ok  out  1`, `inst_data_ok  out  1`, `inst_rdata  out  32`: fetch handshake and returned data.
- `data_req  in  1`, `data_wr  in  1`, `data_size  in  2`, `data_wstrb  in  4`, `data_addr  in  32`, `data_wdata  in  32`: load/store request.
- `data_addr_ok  out  1`, `data_data_ok  out  1`, `data_rdata  out  32`: load/store handshake and returned data.
- `mem_req  out  1`, `mem_wr  out  1`, `mem_size  out  2`, `mem_wstrb  out  4`, `mem_addr  out  32`, `mem_wdata  out  32`: downstream request.
- `mem_addr_ok  in  1`, `mem_data_ok  in  1`, `mem_rdata  in  32`: downstream handshake and returned data.

## Operation
- Grant FSM states: `IDLE`, `LOCK_INST`, `LOCK_DATA`.
- In `IDLE`, when a slot is free (`cnt < MAX_OUTSTANDING`):
  - `data_req` wins over `inst_req`.
  - The winner's fields drive `mem_*` combinationally in the same cycle.
- Handshake fires on `mem_req & mem_addr_ok`:
  - Push the winner ID (`ID_INST`=0, `ID_DATA`=1) into the order FIFO.
  - Assert the winner's `*_addr_ok`.
  - FSM stays in or returns to `IDLE`.
- If `mem_req` is asserted without `mem_addr_ok`, the FSM moves to `LOCK_<winner>`.
  - The grant is held on that requester until its handshake, even if the other requester asserts.
  - This satisfies the sram-like rule that a request stays stable until `addr_ok`.
- Fetch requests drive `mem_wr`=0, `mem_size`=2, `mem_wstrb`=0.
- `mem_req` is 0 whenever `cnt == MAX_OUTSTANDING`, regardless of requester state. A pop in the same cycle does not free a slot for that cycle (no bypass).
- On `mem_data_ok`:
  - Pop the FIFO head and pulse `inst_data_ok` or `data_data_ok` according to the head ID.
  - `mem_rdata` passes through to both `*_rdata` buses unmodified.
- Simultaneous push and pop: both happen, and `cnt` is unchanged.
- `mem_data_ok` with an empty FIFO is ignored; no `*_data_ok` is raised and `cnt` stays 0.
- FIFO pointers are `$clog2(MAX_OUTSTANDING)` bits wide (minimum 1) and wrap modulo `MAX_OUTSTANDING`. `cnt` is `$clog2(MAX_OUTSTANDING+1)` bits wide.
- Ordering is strictly in-order; responses are never reordered.

## Timing
- Reset (asynchronous, immediate):
  - FSM goes to `IDLE`; FIFO is empty; `cnt`=0.
  - All outputs are 0 while `reset`=1.
- Request-to-downstream latency is 0 cycles: `*_req` → `mem_req` is combinational.
- `*_addr_ok` and `*_data_ok` are combinational from `mem_addr_ok`/`mem_data_ok` gated by internal state. They are single-cycle pulses per transaction.
- A `mem_data_ok` in the same cycle as the handshake of that same transaction is not supported; memory returns data no earlier than the cycle after `addr_ok`.
- Reset mid-transaction discards all outstanding IDs. Any stale `mem_data_ok` seen after reset falls under the empty-FIFO rule.

## Configuration
- `MEM_ARB_PERF_CNT_EN`:
  - When defined, adds outputs `perf_inst_grant  out  32`, `perf_data_grant  out  32` and `perf_stall  out  32`.
  - `perf_inst_grant` and `perf_data_grant` increment on each handshake for their requester.
  - `perf_stall` increments on every cycle with (`inst_req|data_req`) and no handshake.
  - Counters reset to 0 and wrap modulo 2^32.
  - When undefined, these ports and counters do not exist.

## Structure
- Shared package `mem_arb_pkg` holds:
  - the requester ID constants `ID_INST` and `ID_DATA`;
  - the FSM state enum (`IDLE`, `LOCK_INST`, `LOCK_DATA`);
  - the `size` encodings (0=byte, 1=half, 2=word).
- Sub-module `arb_id_fifo` is a parameterized 1-bit-wide, depth-`MAX_OUTSTANDING` FIFO. It provides `push`, `pop`, `head`, `cnt`, `full` and `empty`.

## Test plan
- Reset 5 cycles, then `inst_req`=1 at `inst_addr`=0x1C000000 with `mem_addr_ok`=1 → `mem_addr`=0x1C000000, `inst_addr_ok`=1 same cycle. A `mem_data_ok` with `mem_rdata`=0x02800404 next cycle → `inst_data_ok`=1, `inst_rdata`=0x02800404.
- `inst_req` and a `data_req` store (addr 0x1C010000, wstrb 0xF) asserted together → data granted first, `mem_wr`=1; fetch granted the next free cycle.
- `inst_req` with `mem_addr_ok`=0 for 3 cycles while `data_req` rises in cycle 1 → `mem_addr` stays 0x1C000000 until addr_ok (`LOCK_INST`), then the data request is granted.
- `MAX_OUTSTANDING`=2 with no `data_ok` for 2 accepted transactions → `mem_req`=0 on the third request. A pop in the same cycle as the third request still stalls it that cycle.
- Transaction order fetch, load, fetch; three `data_ok` pulses with rdata A, B, C → `inst_data_ok`(A), `data_data_ok`(B), `inst_data_ok`(C).
- Assert `reset` with 2 outstanding, then pulse `mem_data_ok` → no `*_data_ok` raised, `cnt`=0. With `MEM_ARB_PERF_CNT_EN` defined, the grant counters read 0 after reset.
